// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a one-cycle bus.
// Level irq while enabled and mtime >= mtimecmp.
module mtimer (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rw_address,
    output logic [31:0] read_data,
    input  logic        read_request,
    output logic        read_response,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    input  logic        write_request,
    output logic        write_response,
    output logic        irq
);

    logic        enable;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_nx;
    logic [63:0] cmp_nx;
    logic        enable_nx;
    logic [31:0] rd_mux;
    logic [31:0] mask;
    logic [2:0]  sel;
    logic        sel_cr;
    logic        sel_tlo;
    logic        sel_thi;
    logic        sel_clo;
    logic        sel_chi;
    logic        addr_unused;

    assign sel = rw_address[4:2];
    assign addr_unused = ^{rw_address[31:5], rw_address[1:0]};

    assign sel_cr  = (sel == 3'd0);
    assign sel_tlo = (sel == 3'd1);
    assign sel_thi = (sel == 3'd2);
    assign sel_clo = (sel == 3'd3);
    assign sel_chi = (sel == 3'd4);

    assign mask = {{8{write_strobe[3]}}, {8{write_strobe[2]}},
                   {8{write_strobe[1]}}, {8{write_strobe[0]}}};

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [31:0] m
    );
        return (old & ~m) | (data & m);
    endfunction

    always_comb begin
        rd_mux = 32'd0;
        unique case (1'b1)
            sel_cr:  rd_mux = {31'd0, enable};
            sel_tlo: rd_mux = mtime[31:0];
            sel_thi: rd_mux = mtime[63:32];
            sel_clo: rd_mux = mtimecmp[31:0];
            sel_chi: rd_mux = mtimecmp[63:32];
            default: rd_mux = 32'd0;
        endcase
    end

    // A write to either mtime half replaces that cycle's increment.
    always_comb begin
        mtime_nx  = mtime;
        cmp_nx    = mtimecmp;
        enable_nx = enable;
        if (write_request && sel_tlo) begin
            mtime_nx[31:0] = merge(mtime[31:0], write_data, mask);
        end else if (write_request && sel_thi) begin
            mtime_nx[63:32] = merge(mtime[63:32], write_data, mask);
        end else if (enable) begin
            mtime_nx = mtime + 64'd1;
        end
        if (write_request && sel_clo) begin
            cmp_nx[31:0] = merge(mtimecmp[31:0], write_data, mask);
        end
        if (write_request && sel_chi) begin
            cmp_nx[63:32] = merge(mtimecmp[63:32], write_data, mask);
        end
        if (write_request && sel_cr && write_strobe[0]) begin
            enable_nx = write_data[0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            enable         <= 1'b0;
            mtime          <= 64'd0;
            mtimecmp       <= '1;
            irq            <= 1'b0;
            read_response  <= 1'b0;
            write_response <= 1'b0;
            read_data      <= 32'd0;
        end else begin
            enable         <= enable_nx;
            mtime          <= mtime_nx;
            mtimecmp       <= cmp_nx;
            irq            <= enable & (mtime >= mtimecmp);
            read_response  <= read_request;
            write_response <= write_request;
            read_data      <= read_request ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer against a closed-form timer model.
// mtime is modelled as anchor value plus elapsed edges.
module tb_mtimer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rw_address = 32'd0;
    logic [31:0] read_data;
    logic        read_request = 1'b0;
    logic        read_response;
    logic [31:0] write_data = 32'd0;
    logic [3:0]  write_strobe = 4'd0;
    logic        write_request = 1'b0;
    logic        write_response;
    logic        irq;

    mtimer dut (
        .clock(clock),
        .reset(reset),
        .rw_address(rw_address),
        .read_data(read_data),
        .read_request(read_request),
        .read_response(read_response),
        .write_data(write_data),
        .write_strobe(write_strobe),
        .write_request(write_request),
        .write_response(write_response),
        .irq(irq)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    longint unsigned cyc = 0;
    bit              m_en = 1'b0;
    logic [63:0]     m_anc_v = 64'd0;
    longint unsigned m_anc_e = 0;
    logic [63:0]     m_cmp = '1;

    logic [31:0] exp_rdata;
    logic        exp_rresp;
    logic        exp_wresp;
    logic        exp_irq;
    logic [63:0] exp_t;

    function automatic logic [63:0] m_time(longint unsigned e);
        if (m_en) return m_anc_v + 64'(e - m_anc_e - 1);
        return m_anc_v;
    endfunction

    function automatic logic [31:0] m_merge(
        logic [31:0] o, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++)
            if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(
        logic [31:0] a, logic [63:0] t);
        case (a[4:2])
            3'd0: return {31'd0, m_en};
            3'd1: return t[31:0];
            3'd2: return t[63:32];
            3'd3: return m_cmp[31:0];
            3'd4: return m_cmp[63:32];
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge: drive request, predict outputs, advance model.
    task automatic step(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        logic [63:0] t;
        read_request  = rd;
        write_request = wr;
        rw_address    = a;
        write_data    = d;
        write_strobe  = s;
        t = m_time(cyc);
        exp_t     = t;
        exp_irq   = reset && m_en && (t >= m_cmp);
        exp_rresp = reset && rd;
        exp_wresp = reset && wr;
        exp_rdata = exp_rresp ? m_read(a, t) : 32'd0;
        @(posedge clock);
        #1;
        if (!reset) begin
            m_en = 1'b0;
            m_anc_v = 64'd0;
            m_cmp = '1;
        end else if (wr) begin
            case (a[4:2])
                3'd0: if (s[0] && (d[0] != m_en)) begin
                    if (d[0]) begin
                        m_anc_v = t;
                        m_anc_e = cyc;
                        m_en = 1'b1;
                    end else begin
                        m_anc_v = t + 64'd1;
                        m_en = 1'b0;
                    end
                end
                3'd1: begin
                    m_anc_v = {t[63:32], m_merge(t[31:0], d, s)};
                    m_anc_e = cyc;
                end
                3'd2: begin
                    m_anc_v = {m_merge(t[63:32], d, s), t[31:0]};
                    m_anc_e = cyc;
                end
                3'd3: m_cmp[31:0] = m_merge(m_cmp[31:0], d, s);
                3'd4: m_cmp[63:32] = m_merge(m_cmp[63:32], d, s);
                default: ;
            endcase
        end
        cyc++;
        read_request  = 1'b0;
        write_request = 1'b0;
        write_strobe  = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(0, 0, 0, 0, 0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] want [5];
        want = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 32'd0, 32'd1, 4'hF);
            total++;
            if (read_response !== 1'b0 || write_response !== 1'b0 ||
                read_data !== 32'd0 || irq !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: rr=%b wr=%b rd=%h irq=%b want 0",
                         read_response, write_response, read_data, irq);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'(i * 4), 0, 0);
            total++;
            if (read_response !== 1'b1 || read_data !== want[i] ||
                read_data !== exp_rdata || irq !== 1'b0) begin
                bad++;
                $display("FAIL reset_reg%0d: rr=%b data=%h irq=%b want %h",
                         i, read_response, read_data, irq, want[i]);
            end
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (read_response !== 1'b0 || read_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_pulse: rr=%b data=%h want 0 0",
                     read_response, read_data);
        end
    endtask

    task automatic test_count();
        do_reset();
        step(0, 1, 32'h0, 32'd1, 4'hF);
        repeat (10) step(0, 0, 0, 0, 0);
        step(1, 0, 32'h4, 0, 0);
        total++;
        if (read_data !== 32'd10 || read_data !== exp_rdata) begin
            bad++;
            $display("FAIL count_lo: got %0d want 10", read_data);
        end
        step(1, 0, 32'h8, 0, 0);
        total++;
        if (read_data !== 32'd0 || read_response !== 1'b1) begin
            bad++;
            $display("FAIL count_hi: got %h rr=%b want 0 1",
                     read_data, read_response);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 32'h4, 32'hFFFF_FFFE, 4'hF);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 32'h8, 0, 0);
        total++;
        if (read_data !== 32'd1 || read_data !== exp_rdata) begin
            bad++;
            $display("FAIL carry_hi: got %h want 1", read_data);
        end
        step(0, 1, 32'h4, 32'hFFFF_FFFF, 4'hF);
        step(0, 1, 32'h8, 32'hFFFF_FFFF, 4'hF);
        step(1, 0, 32'h4, 0, 0);
        step(1, 0, 32'h8, 0, 0);
        total++;
        if (read_data !== 32'd0 || read_data !== exp_rdata) begin
            bad++;
            $display("FAIL wrap_hi: got %h want 0", read_data);
        end
        step(1, 0, 32'h4, 0, 0);
        total++;
        if (read_data !== exp_rdata || read_data > 32'd4) begin
            bad++;
            $display("FAIL wrap_lo: got %h want %h", read_data, exp_rdata);
        end
    endtask

    task automatic test_irq();
        bit seen;
        seen = 1'b0;
        do_reset();
        step(0, 1, 32'h10, 32'd0, 4'hF);
        step(0, 1, 32'hC, 32'd20, 4'hF);
        step(0, 1, 32'h0, 32'd1, 4'hF);
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 0, 0, 0, 0);
            total++;
            if (irq !== exp_irq) begin
                bad++;
                $display("FAIL irq_track: got %b want %b at mtime %0d",
                         irq, exp_irq, exp_t);
            end
            if (irq === 1'b1) begin
                seen = 1'b1;
                total++;
                if (exp_t !== 64'd20) begin
                    bad++;
                    $display("FAIL irq_rise: rose at mtime %0d want 20",
                             exp_t);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL irq_timeout: irq=%b want 1", irq);
        end
        step(0, 1, 32'hC, 32'hFFFF_FFFF, 4'hF);
        total++;
        if (irq !== 1'b1 || irq !== exp_irq) begin
            bad++;
            $display("FAIL irq_hold: got %b want 1", irq);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (irq !== 1'b0 || irq !== exp_irq) begin
            bad++;
            $display("FAIL irq_fall: got %b want 0", irq);
        end
    endtask

    task automatic test_strobe();
        step(0, 1, 32'hC, 32'hFFFF_FFFF, 4'hF);
        step(0, 1, 32'hC, 32'hAABB_CCDD, 4'b0101);
        step(1, 0, 32'hC, 0, 0);
        total++;
        if (read_data !== 32'hFFBB_FFDD || read_data !== exp_rdata) begin
            bad++;
            $display("FAIL strobe: got %h want ffbbffdd", read_data);
        end
        step(0, 1, 32'h10, 32'h1234_5678, 4'b0000);
        total++;
        if (write_response !== 1'b1) begin
            bad++;
            $display("FAIL strobe0_resp: got %b want 1", write_response);
        end
        step(1, 0, 32'h10, 0, 0);
        total++;
        if (read_data !== exp_rdata) begin
            bad++;
            $display("FAIL strobe0: got %h want %h", read_data, exp_rdata);
        end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        int k;
        do_reset();
        step(0, 1, 32'h0, 32'd1, 4'hF);
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 4)) step(0, 0, 0, 0, 0);
            v = $urandom & 32'h7FFF_FFFF;
            k = $urandom_range(0, 5);
            step(0, 1, 32'h4, v, 4'hF);
            repeat (k) step(0, 0, 0, 0, 0);
            step(1, 0, 32'h4, 0, 0);
            total++;
            if (read_data !== v + 32'(k) || read_data !== exp_rdata) begin
                bad++;
                $display("FAIL priority: got %h want %h",
                         read_data, v + 32'(k));
            end
        end
    endtask

    task automatic test_unmapped();
        for (int a = 5; a < 8; a++) begin
            step(0, 1, 32'(a * 4), $urandom, 4'hF);
            step(1, 0, 32'(a * 4), 0, 0);
            total++;
            if (read_data !== 32'd0 || read_response !== 1'b1) begin
                bad++;
                $display("FAIL unmapped_%0h: got %h rr=%b want 0 1",
                         a * 4, read_data, read_response);
            end
            step(0, 0, 0, 0, 0);
            total++;
            if (read_response !== 1'b0) begin
                bad++;
                $display("FAIL unmapped_pulse: rr=%b want 0", read_response);
            end
        end
    endtask

    task automatic test_simul();
        do_reset();
        step(1, 1, 32'h0, 32'd1, 4'hF);
        total++;
        if (read_data !== 32'd0 || read_response !== 1'b1 ||
            write_response !== 1'b1) begin
            bad++;
            $display("FAIL simul: data=%h rr=%b wr=%b want 0 1 1",
                     read_data, read_response, write_response);
        end
        step(1, 0, 32'h0, 0, 0);
        total++;
        if (read_data !== 32'd1 || write_response !== 1'b0) begin
            bad++;
            $display("FAIL simul_next: data=%h wr=%b want 1 0",
                     read_data, write_response);
        end
    endtask

    task automatic test_random();
        bit rd, wr;
        logic [31:0] a, d;
        logic [3:0] s;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) != 0);
            rd = $urandom_range(0, 1);
            wr = ($urandom_range(0, 2) == 0);
            a = {$urandom, 2'b00};
            d = $urandom;
            if (a[4:2] == 3'd4 || a[4:2] == 3'd2)
                d = d & 32'h0000_0003;
            s = $urandom;
            step(rd, wr, a, d, s);
            total++;
            if (read_response !== exp_rresp || read_data !== exp_rdata ||
                write_response !== exp_wresp || irq !== exp_irq) begin
                bad++;
                $display("FAIL rand%0d: rr=%b rd=%h wr=%b irq=%b want %b %h %b %b",
                         i, read_response, read_data, write_response, irq,
                         exp_rresp, exp_rdata, exp_wresp, exp_irq);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_irq();
        test_strobe();
        test_priority();
        test_unmapped();
        test_simul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
